// File: rtl/multicycle_ctrl_if.sv
// Decode-class inputs and latch/enable/counter outputs between the multi-cycle controller and the LA32 datapath.
interface multicycle_ctrl_if #(parameter int CNT_W = 32) ();
    logic             inst_br_only;
    logic             inst_load;
    logic             inst_store;
    logic             inst_gr_we;
    logic             br_taken;
    logic             halt_req;
    logic [2:0]       state;
    logic             inst_sram_en;
    logic             ir_we;
    logic             pc_we;
    logic             pc_sel_br;
    logic             exe_latch_we;
    logic             data_sram_en;
    logic             data_sram_we;
    logic             mdr_we;
    logic             rf_we;
    logic             inst_retire;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  inst_br_only, inst_load, inst_store, inst_gr_we, br_taken, halt_req,
        output state, inst_sram_en, ir_we, pc_we, pc_sel_br, exe_latch_we,
               data_sram_en, data_sram_we, mdr_we, rf_we, inst_retire,
               cycle_cnt, retire_cnt
    );

    modport slave (
        output inst_br_only, inst_load, inst_store, inst_gr_we, br_taken, halt_req,
        input  state, inst_sram_en, ir_we, pc_we, pc_sel_br, exe_latch_we,
               data_sram_en, data_sram_we, mdr_we, rf_we, inst_retire,
               cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequences the LA32 multi-cycle datapath through IF/ID/EXE/MEM/WB, stretching IF and MEM to MEM_LAT cycles.
// Outputs are combinational from state/wcnt/br_q/inputs; halt_req stalls only at the first IF cycle.
module multicycle_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);
    localparam int            WCW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t           state;
    logic [WCW-1:0]   wcnt;
    logic             br_q;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    logic last;
    logic stall;
    logic inst_sram_en, ir_we, pc_we, pc_sel_br, exe_latch_we;
    logic data_sram_en, data_sram_we, mdr_we, rf_we, retire;

    assign last  = (wcnt == WLAST);
    // A halt is honoured only before the fetch starts, never mid-access.
    assign stall = bus.halt_req && (wcnt == '0);

    always_comb begin
        inst_sram_en = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel_br    = 1'b0;
        exe_latch_we = 1'b0;
        data_sram_en = 1'b0;
        data_sram_we = 1'b0;
        mdr_we       = 1'b0;
        rf_we        = 1'b0;
        retire       = 1'b0;
        if (!reset) begin
            case (state)
                S_IF: begin
                    inst_sram_en = !stall;
                    ir_we        = !stall && last;
                end
                S_ID: begin
                    if (bus.inst_br_only) begin
                        retire    = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel_br = bus.br_taken;
                    end
                end
                S_EXE: exe_latch_we = 1'b1;
                S_MEM: begin
                    data_sram_en = 1'b1;
                    data_sram_we = bus.inst_store && (wcnt == '0);
                    if (last) begin
                        mdr_we = bus.inst_load;
                        if (!bus.inst_load) begin
                            retire    = 1'b1;
                            pc_we     = 1'b1;
                            pc_sel_br = br_q;
                        end
                    end
                end
                S_WB: begin
                    rf_we     = bus.inst_gr_we;
                    retire    = 1'b1;
                    pc_we     = 1'b1;
                    pc_sel_br = br_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IF;
            wcnt       <= '0;
            br_q       <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire)
                retire_cnt <= retire_cnt + CNT_W'(1);
            case (state)
                S_IF: begin
                    if (!stall) begin
                        if (last) begin
                            state <= S_ID;
                            wcnt  <= '0;
                        end else begin
                            wcnt <= wcnt + WCW'(1);
                        end
                    end
                end
                S_ID: begin
                    br_q  <= bus.br_taken;
                    state <= bus.inst_br_only ? S_IF : S_EXE;
                    wcnt  <= '0;
                end
                S_EXE: begin
                    state <= (bus.inst_load || bus.inst_store) ? S_MEM : S_WB;
                    wcnt  <= '0;
                end
                S_MEM: begin
                    if (last) begin
                        state <= bus.inst_load ? S_WB : S_IF;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                S_WB: begin
                    state <= S_IF;
                    wcnt  <= '0;
                end
                default: begin
                    state <= S_IF;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    assign bus.state        = state;
    assign bus.inst_sram_en = inst_sram_en;
    assign bus.ir_we        = ir_we;
    assign bus.pc_we        = pc_we;
    assign bus.pc_sel_br    = pc_sel_br;
    assign bus.exe_latch_we = exe_latch_we;
    assign bus.data_sram_en = data_sram_en;
    assign bus.data_sram_we = data_sram_we;
    assign bus.mdr_we       = mdr_we;
    assign bus.rf_we        = rf_we;
    assign bus.inst_retire  = retire;
    assign bus.cycle_cnt    = cycle_cnt;
    assign bus.retire_cnt   = retire_cnt;
endmodule
